// File: rtl/mac_result_scoreboard.sv
// ============================================================================
// Module  : mac_result_scoreboard
// Brief   : Recomputes the biased pixel*weight dot product from the stream and
//           checks the DUT's result/cat bit; counts mismatches, protocol
//           errors and timeouts.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_result_scoreboard #(
    parameter int LANES    = 3,
    parameter int PIXEL_W  = 8,
    parameter int WEIGHT_W = 8,
    parameter int WORDS    = 4096,
    parameter int RESULT_W = 32,
    parameter int BIAS_W   = 16,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIAS_W-1:0]         bias,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LANES*PIXEL_W-1:0]  s_pixels,
    input  logic [LANES*WEIGHT_W-1:0] s_weights,
    input  logic                      dut_valid,
    input  logic [RESULT_W-1:0]       dut_result,
    input  logic                      dut_cat,
    output logic                      busy,
    output logic                      exp_valid,
    output logic [RESULT_W-1:0]       exp_result,
    output logic                      exp_cat,
    output logic                      match,
    output logic                      mismatch,
    output logic                      proto_err,
    output logic                      timeout,
    output logic [CNT_W-1:0]          err_cnt,
    output logic [CNT_W-1:0]          frame_cnt
);

    localparam int PROD_W = PIXEL_W + WEIGHT_W + 1;
    localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCUM    = 2'd1,
        S_WAIT_DUT = 2'd2,
        S_REPORT   = 2'd3
    } state_t;

    state_t                      r_state;
    logic signed [RESULT_W-1:0]  r_acc;
    logic [BEAT_W-1:0]           r_beat;
    logic [TCNT_W-1:0]           r_tcnt;
    logic                        r_exp_pend;
    logic                        r_s_ready;
    logic                        r_exp_valid;
    logic [RESULT_W-1:0]         r_exp_result;
    logic                        r_exp_cat;
    logic                        r_match;
    logic                        r_mismatch;
    logic                        r_proto_err;
    logic                        r_timeout;
    logic [CNT_W-1:0]            r_err_cnt;
    logic [CNT_W-1:0]            r_frame_cnt;

    logic signed [PROD_W-1:0]    w_prod [LANES];
    logic signed [RESULT_W-1:0]  w_beat_sum;
    logic                        w_accept;
    logic                        w_acc_pos;
    logic                        w_cmp_ok;
    logic                        w_dut_hit;
    logic                        w_to_hit;
    logic                        w_proto;
    logic                        w_any_err;

    // Pixels are unsigned: a zero MSB makes them non-negative in the signed multiply.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [PIXEL_W:0]    w_pix;
        logic signed [WEIGHT_W-1:0] w_wgt;
        assign w_pix       = {1'b0, s_pixels[gi*PIXEL_W +: PIXEL_W]};
        assign w_wgt       = s_weights[gi*WEIGHT_W +: WEIGHT_W];
        assign w_prod[gi]  = PROD_W'(w_pix) * PROD_W'(w_wgt);
    end

    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_beat_sum = w_beat_sum + RESULT_W'(w_prod[i]);
        end
    end

    // While waiting on the DUT the accumulator already holds the final sum,
    // so the compare is taken against it directly on the dut_valid edge.
    always_comb begin
        w_accept  = s_valid && r_s_ready && (r_state == S_ACCUM);
        w_acc_pos = (r_acc > 0);
        w_cmp_ok  = (dut_result == r_acc) && (dut_cat == w_acc_pos);
        w_dut_hit = (r_state == S_WAIT_DUT) && dut_valid;
        w_to_hit  = (r_state == S_WAIT_DUT) && !dut_valid &&
                    (r_tcnt == TCNT_W'(TIMEOUT - 1));
        w_proto   = (dut_valid && ((r_state == S_IDLE) || (r_state == S_ACCUM))) ||
                    (start && (r_state != S_IDLE));
        w_any_err = w_proto || (w_dut_hit && !w_cmp_ok) || w_to_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_beat       <= '0;
            r_tcnt       <= '0;
            r_exp_pend   <= 1'b0;
            r_s_ready    <= 1'b0;
            r_exp_valid  <= 1'b0;
            r_exp_result <= '0;
            r_exp_cat    <= 1'b0;
            r_match      <= 1'b0;
            r_mismatch   <= 1'b0;
            r_proto_err  <= 1'b0;
            r_timeout    <= 1'b0;
            r_err_cnt    <= '0;
            r_frame_cnt  <= '0;
        end else begin
            r_match     <= w_dut_hit && w_cmp_ok;
            r_mismatch  <= w_dut_hit && !w_cmp_ok;
            r_proto_err <= w_proto;
            r_timeout   <= w_to_hit;
            if (w_any_err && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_dut_hit) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (r_exp_pend) begin
                r_exp_result <= r_acc;
                r_exp_cat    <= w_acc_pos;
                r_exp_valid  <= 1'b1;
                r_exp_pend   <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc       <= {{(RESULT_W-BIAS_W){bias[BIAS_W-1]}}, bias};
                        r_beat      <= '0;
                        r_exp_valid <= 1'b0;
                        r_s_ready   <= 1'b1;
                        r_state     <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc  <= r_acc + w_beat_sum;
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == BEAT_W'(WORDS - 1)) begin
                            r_s_ready  <= 1'b0;
                            r_tcnt     <= '0;
                            r_exp_pend <= 1'b1;
                            r_state    <= S_WAIT_DUT;
                        end
                    end
                end
                S_WAIT_DUT: begin
                    if (dut_valid) begin
                        r_state <= S_REPORT;
                    end else if (w_to_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign busy       = (r_state != S_IDLE);
    assign exp_valid  = r_exp_valid;
    assign exp_result = r_exp_result;
    assign exp_cat    = r_exp_cat;
    assign match      = r_match;
    assign mismatch   = r_mismatch;
    assign proto_err  = r_proto_err;
    assign timeout    = r_timeout;
    assign err_cnt    = r_err_cnt;
    assign frame_cnt  = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mac_result_scoreboard.sv
// ============================================================================
// Module  : tb_mac_result_scoreboard
// Brief   : Directed self-checking bench for mac_result_scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_result_scoreboard;

    localparam int LANES    = 3;
    localparam int PIXEL_W  = 8;
    localparam int WEIGHT_W = 8;
    localparam int WORDS    = 4;
    localparam int RESULT_W = 32;
    localparam int BIAS_W   = 16;
    localparam int TIMEOUT  = 8;
    localparam int CNT_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [BIAS_W-1:0]         bias;
    logic                      s_valid;
    logic                      s_ready;
    logic [LANES*PIXEL_W-1:0]  s_pixels;
    logic [LANES*WEIGHT_W-1:0] s_weights;
    logic                      dut_valid;
    logic [RESULT_W-1:0]       dut_result;
    logic                      dut_cat;
    logic                      busy;
    logic                      exp_valid;
    logic [RESULT_W-1:0]       exp_result;
    logic                      exp_cat;
    logic                      match;
    logic                      mismatch;
    logic                      proto_err;
    logic                      timeout;
    logic [CNT_W-1:0]          err_cnt;
    logic [CNT_W-1:0]          frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int m_err    = 0;
    int m_frame  = 0;

    mac_result_scoreboard #(
        .LANES(LANES), .PIXEL_W(PIXEL_W), .WEIGHT_W(WEIGHT_W), .WORDS(WORDS),
        .RESULT_W(RESULT_W), .BIAS_W(BIAS_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixels(s_pixels), .s_weights(s_weights),
        .dut_valid(dut_valid), .dut_result(dut_result), .dut_cat(dut_cat),
        .busy(busy), .exp_valid(exp_valid), .exp_result(exp_result), .exp_cat(exp_cat),
        .match(match), .mismatch(mismatch), .proto_err(proto_err), .timeout(timeout),
        .err_cnt(err_cnt), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void bump_err();
        m_err = (m_err == 3) ? 3 : m_err + 1;
    endfunction

    // Start a frame and stream WORDS identical beats; optional random gaps and
    // an optional dut_valid on beat dv_at (a protocol violation).
    task automatic run_frame(input int b, input int p0, input int p1, input int p2,
                             input int w0, input int w1, input int w2,
                             input bit gaps, input int dv_at);
        start = 1'b1;
        bias  = b[BIAS_W-1:0];
        tick();
        start = 1'b0;
        chk("s_ready_in_accum", s_ready, 1);
        for (int k = 0; k < WORDS; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    tick();
                end
            end
            s_valid   = 1'b1;
            s_pixels  = {p2[7:0], p1[7:0], p0[7:0]};
            s_weights = {w2[7:0], w1[7:0], w0[7:0]};
            dut_valid = (k == dv_at);
            tick();
            if (k == dv_at) begin
                bump_err();
                chk("proto_err_accum", proto_err, 1);
                chk("err_cnt_proto", err_cnt, m_err);
            end
            dut_valid = 1'b0;
        end
        s_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int want_res, input int want_cat,
                                input int dres, input int dcat, input bit ok);
        chk({tag, "_exp_valid_early"}, exp_valid, 0);
        tick();
        chk({tag, "_exp_valid"}, exp_valid, 1);
        chk({tag, "_exp_result"}, $signed(exp_result), want_res);
        chk({tag, "_exp_cat"}, exp_cat, want_cat);
        dut_valid  = 1'b1;
        dut_result = dres;
        dut_cat    = dcat[0];
        tick();
        dut_valid = 1'b0;
        m_frame   = (m_frame + 1) % 4;
        if (!ok) bump_err();
        chk({tag, "_match"}, match, ok);
        chk({tag, "_mismatch"}, mismatch, !ok);
        chk({tag, "_frame_cnt"}, frame_cnt, m_frame);
        chk({tag, "_err_cnt"}, err_cnt, m_err);
        tick();
        chk({tag, "_match_clear"}, match | mismatch, 0);
        chk({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bias = '0; s_valid = 1'b0;
        s_pixels = '0; s_weights = '0; dut_valid = 1'b0; dut_result = '0; dut_cat = 1'b0;
        tick(); tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_exp_valid", exp_valid, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        tick();

        // 4*(1+2+3) - 10 = 14
        run_frame(-10, 1, 2, 3, 1, 1, 1, 1'b0, -1);
        finish_frame("a_ok", 14, 1, 14, 1, 1'b1);
        run_frame(-10, 1, 2, 3, 1, 1, 1, 1'b0, -1);
        finish_frame("a_badcat", 14, 1, 14, 0, 1'b0);

        // 4*3*(255*-128) = -391680, with stalls
        run_frame(0, 255, 255, 255, -128, -128, -128, 1'b1, -1);
        finish_frame("b_neg", -391680, 0, -391680, 0, 1'b1);

        // Protocol error during ACCUM, then no DUT response -> timeout
        run_frame(-10, 1, 2, 3, 1, 1, 1, 1'b0, 1);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            if (timeout) chk("timeout_early", timeout, 0);
        end
        tick();
        bump_err();
        chk("timeout_pulse", timeout, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_err_cnt", err_cnt, m_err);
        chk("timeout_frame_cnt", frame_cnt, m_frame);
        tick();
        chk("timeout_clear", timeout, 0);

        // err_cnt now at 3; further errors must saturate
        run_frame(-10, 1, 2, 3, 1, 1, 1, 1'b0, -1);
        finish_frame("a_badres", 14, 1, 13, 1, 1'b0);
        run_frame(0, 9, 7, 5, 0, 0, 0, 1'b0, -1);
        finish_frame("c_zero", 0, 0, 0, 1, 1'b0);

        // Reset on beat 2 of 4 aborts the frame
        start = 1'b1; bias = 16'd5;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_pixels = {8'd3, 8'd2, 8'd1}; s_weights = {8'd1, 8'd1, 8'd1};
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; s_valid = 1'b0;
        m_err = 0; m_frame = 0;
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_exp_result", exp_result, 0);
        chk("midrst_pulses", {match, mismatch, proto_err, timeout}, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        run_frame(-10, 1, 2, 3, 1, 1, 1, 1'b0, -1);
        finish_frame("after_rst", 14, 1, 14, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
